iter_alu: RTL and testbench

- Multi-cycle, parametrised successor to the single-cycle combinational ALU of the accumulator datapath.
- Keeps the existing 4-bit opcode map and generalises the datapath width.
- Adds a start/ready/done handshake, status flags, full-width multiply (high half returned), remainder on divide, variable shift amounts and divide-by-zero detection.
- Sits between the accumulator/MBR operand paths and the control unit, which sequences on done.

---
 rtl/iter_alu_pkg.sv | 25 ++
 rtl/iter_muldiv.sv | 77 +++++++
 rtl/iter_alu.sv | 192 +++++++++++++++++++
 tb/tb_iter_alu.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iter_alu_pkg.sv
// Shared opcode map, FSM encoding and engine modes for the iterative ALU.
package iter_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_ROL  = 4'h6;
    localparam logic [3:0] OP_ROR  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    typedef enum logic {ModeMul, ModeDiv} mode_e;

endpackage

// File: rtl/iter_muldiv.sv
// Shared WIDTH-iteration engine: shift-add multiply or restoring divide.
// lo/hi carry the value of the final step so the caller can capture them on finish.
module iter_muldiv
    import iter_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             finish,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam logic [SHW:0] LastIter = (SHW + 1)'(WIDTH - 1);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q;
    logic [SHW:0]     cnt_q;
    logic             busy_q;
    mode_e            mode_q;
    logic [WIDTH:0]   add_sum, rem_shift, rem_diff;

    // Multiply: hi accumulates, lo holds the multiplier and collects product bits.
    // Divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
    always_comb begin
        add_sum   = {1'b0, hi_q} + {1'b0, {WIDTH{lo_q[0]}} & b_q};
        rem_shift = {hi_q, lo_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, b_q};
        if (mode_q == ModeMul) begin
            hi_d = add_sum[WIDTH:1];
            lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
        end else if (!rem_diff[WIDTH]) begin
            hi_d = rem_diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            hi_d = rem_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            mode_q <= ModeMul;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= a;
            b_q    <= b;
            mode_q <= mode;
        end else if (busy_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
            if (finish) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy   = busy_q;
    assign finish = busy_q && (cnt_q == LastIter);
    assign lo     = lo_d;
    assign hi     = hi_d;

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle ALU: start/ready/done handshake, single-cycle ops, flags,
// and an iterative multiply/divide engine.
module iter_alu
    import iter_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_zero,
    output logic             flag_neg,
    output logic             flag_carry,
    output logic             flag_ovf,
    output logic             div_by_zero
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned Msb = WIDTH - 1;

    state_e           state_q, state_d;
    logic             eng_start, eng_busy, eng_finish;
    mode_e            eng_mode;
    logic [WIDTH-1:0] eng_lo, eng_hi;

    logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
    logic             zero_q, zero_d, neg_q, neg_d, carry_q, carry_d, ovf_q, ovf_d;
    logic             dbz_q, dbz_d, done_q, done_d;

    logic [SHW-1:0]   shamt;
    logic [SHW:0]     rsh;
    logic [WIDTH:0]   sum, diff, shl_ext, shr_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry, alu_ovf;

    iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (eng_start),
        .mode   (eng_mode),
        .a      (operand1),
        .b      (operand2),
        .busy   (eng_busy),
        .finish (eng_finish),
        .lo     (eng_lo),
        .hi     (eng_hi)
    );

    // One extra bit on each shift catches the last bit shifted out; it stays 0 when n=0.
    always_comb begin
        shamt   = operand2[SHW-1:0];
        rsh     = (SHW + 1)'(WIDTH) - {1'b0, shamt};
        sum     = {1'b0, operand1} + {1'b0, operand2};
        diff    = {1'b0, operand1} - {1'b0, operand2};
        shl_ext = {1'b0, operand1} << shamt;
        shr_ext = {operand1, 1'b0} >> shamt;
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (operand1[Msb] == operand2[Msb]) && (sum[Msb] != operand1[Msb]);
            end
            OP_SUB: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
                alu_ovf   = (operand1[Msb] != operand2[Msb]) && (diff[Msb] != operand1[Msb]);
            end
            OP_SHL: begin
                alu_res   = shl_ext[WIDTH-1:0];
                alu_carry = shl_ext[WIDTH];
            end
            OP_SHR: begin
                alu_res   = shr_ext[WIDTH:1];
                alu_carry = shr_ext[0];
            end
            OP_ROL:  alu_res = (operand1 << shamt) | (operand1 >> rsh);
            OP_ROR:  alu_res = (operand1 >> shamt) | (operand1 << rsh);
            OP_AND:  alu_res = operand1 & operand2;
            OP_OR:   alu_res = operand1 | operand2;
            OP_XOR:  alu_res = operand1 ^ operand2;
            OP_NOR:  alu_res = ~(operand1 | operand2);
            OP_NAND: alu_res = ~(operand1 & operand2);
            OP_XNOR: alu_res = ~(operand1 ^ operand2);
            OP_GT:   alu_res = {{(WIDTH - 1){1'b0}}, operand1 > operand2};
            OP_EQ:   alu_res = {{(WIDTH - 1){1'b0}}, operand1 == operand2};
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        eng_start   = 1'b0;
        eng_mode    = ModeMul;
        done_d      = 1'b0;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        dbz_d       = dbz_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        case (state_q)
            StIdle: begin
                if (start && ready) begin
                    if (opcode == OP_MUL) begin
                        state_d   = StMul;
                        eng_start = 1'b1;
                    end else if (opcode == OP_DIV && operand2 != '0) begin
                        state_d   = StDiv;
                        eng_start = 1'b1;
                        eng_mode  = ModeDiv;
                    end else begin
                        done_d      = 1'b1;
                        result_d    = alu_res;
                        result_hi_d = '0;
                        carry_d     = alu_carry;
                        ovf_d       = alu_ovf;
                        dbz_d       = 1'b0;
                        if (opcode == OP_DIV) begin
                            result_d    = '1;
                            result_hi_d = operand1;
                            dbz_d       = 1'b1;
                        end
                    end
                end
            end
            StMul, StDiv: begin
                if (eng_finish) begin
                    state_d     = StIdle;
                    done_d      = 1'b1;
                    result_d    = eng_lo;
                    result_hi_d = eng_hi;
                    carry_d     = (state_q == StMul) && (eng_hi != '0);
                    ovf_d       = 1'b0;
                    dbz_d       = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (done_d) begin
            zero_d = (result_d == '0);
            neg_d  = result_d[Msb];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            done_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            dbz_q       <= dbz_d;
        end
    end

    assign ready       = (state_q == StIdle) && !eng_busy;
    assign done        = done_q;
    assign result      = result_q;
    assign result_hi   = result_hi_q;
    assign flag_zero   = zero_q;
    assign flag_neg    = neg_q;
    assign flag_carry  = carry_q;
    assign flag_ovf    = ovf_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu (WIDTH=16): directed table, handshake corner
// cases and random operations against an arithmetic reference model.
module tb_iter_alu;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [3:0]  opcode;
    logic [15:0] operand1, operand2;
    logic        ready, done, flag_zero, flag_neg, flag_carry, flag_ovf, div_by_zero;
    logic [15:0] result, result_hi;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a, b, res, hi;
        logic [3:0]  flg;  // {zero, neg, carry, ovf}
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    iter_alu #(
        .WIDTH (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .opcode      (opcode),
        .operand1    (operand1),
        .operand2    (operand2),
        .ready       (ready),
        .done        (done),
        .result      (result),
        .result_hi   (result_hi),
        .flag_zero   (flag_zero),
        .flag_neg    (flag_neg),
        .flag_carry  (flag_carry),
        .flag_ovf    (flag_ovf),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [15:0] a, b, res, hi,
                                input logic [3:0] flg, input logic dbz, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.hi = hi;
        v.flg = flg; v.dbz = dbz; v.lat = lat;
        return v;
    endfunction

    // Reference model from plain integer arithmetic.
    function automatic vec_t model(input logic [3:0] op, input logic [15:0] a, b);
        vec_t v;
        longint unsigned ua, ub, r, h, w;
        longint sa, sb, s;
        int n;
        logic c, o;
        ua = 64'(a); ub = 64'(b);
        sa = longint'($signed(a)); sb = longint'($signed(b));
        n = int'(b % 16);
        r = 0; h = 0; c = 1'b0; o = 1'b0;
        v.dbz = 1'b0; v.lat = 1;
        case (op)
            4'h0: begin
                w = ua + ub; r = w; c = (w > 64'hFFFF);
                s = sa + sb; o = (s > 32767) || (s < -32768);
            end
            4'h1: begin
                r = (ua - ub) & 64'hFFFF; c = (ua < ub);
                s = sa - sb; o = (s > 32767) || (s < -32768);
            end
            4'h2: begin
                w = ua * ub; r = w & 64'hFFFF; h = w >> 16; c = (h != 0); v.lat = 17;
            end
            4'h3: begin
                if (ub == 0) begin
                    r = 64'hFFFF; h = ua; v.dbz = 1'b1;
                end else begin
                    r = ua / ub; h = ua % ub; v.lat = 17;
                end
            end
            4'h4: begin r = ua << n; c = (n != 0) && (((ua >> (16 - n)) & 1) == 1); end
            4'h5: begin r = ua >> n; c = (n != 0) && (((ua >> (n - 1)) & 1) == 1); end
            4'h6: r = (ua << n) | (ua >> (16 - n));
            4'h7: r = (ua >> n) | (ua << (16 - n));
            4'h8: r = ua & ub;
            4'h9: r = ua | ub;
            4'hA: r = ua ^ ub;
            4'hB: r = ~(ua | ub);
            4'hC: r = ~(ua & ub);
            4'hD: r = ~(ua ^ ub);
            4'hE: r = (ua > ub) ? 1 : 0;
            default: r = (ua == ub) ? 1 : 0;
        endcase
        v.op = op; v.a = a; v.b = b;
        v.res = 16'(r & 64'hFFFF);
        v.hi = 16'(h & 64'hFFFF);
        v.flg = {v.res == 16'h0, v.res[15], c, o};
        return v;
    endfunction

    task automatic run_vec(input vec_t e, input string name);
        int w, lat, busy_rdy;
        @(negedge clk);
        w = 0;
        while (!ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({name, " ready_before"}, 64'(ready), 64'd1);
        start = 1'b1; opcode = e.op; operand1 = e.a; operand2 = e.b;
        @(posedge clk); #1;
        // Scramble inputs after acceptance; they must not matter.
        start = 1'b0; opcode = 4'($urandom); operand1 = 16'($urandom); operand2 = 16'($urandom);
        lat = 1; busy_rdy = 0;
        while (!done && lat < 40) begin
            if (ready) busy_rdy++;
            @(posedge clk); #1;
            lat++;
        end
        chk({name, " latency"}, 64'(lat), 64'(e.lat));
        if (e.lat > 1) chk({name, " ready_while_busy"}, 64'(busy_rdy), 64'd0);
        chk({name, " ready_at_done"}, 64'(ready), 64'd1);
        chk({name, " result"}, 64'(result), 64'(e.res));
        chk({name, " result_hi"}, 64'(result_hi), 64'(e.hi));
        chk({name, " flags"}, 64'({flag_zero, flag_neg, flag_carry, flag_ovf}), 64'(e.flg));
        chk({name, " div_by_zero"}, 64'(div_by_zero), 64'(e.dbz));
        @(posedge clk); #1;
        chk({name, " done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int ndone, first;
        logic [3:0]  rop;
        logic [15:0] ra, rb;

        reset = 1'b1; start = 1'b0; opcode = 4'h0; operand1 = 16'h0; operand2 = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", 64'(ready), 64'd1);
        chk("reset done", 64'(done), 64'd0);
        chk("reset result", 64'({result, result_hi}), 64'd0);
        chk("reset flags", 64'({flag_zero, flag_neg, flag_carry, flag_ovf, div_by_zero}), 64'd0);
        reset = 1'b0;

        //                   op     A         B         res       hi        zncv     dbz   lat
        tbl.push_back(mk(4'h0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b1010, 1'b0, 1));
        tbl.push_back(mk(4'h1, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'b0001, 1'b0, 1));
        tbl.push_back(mk(4'h2, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 4'b0010, 1'b0, 17));
        tbl.push_back(mk(4'h3, 16'd100,  16'd7,    16'd14,   16'd2,    4'b0000, 1'b0, 17));
        tbl.push_back(mk(4'h3, 16'd5,    16'd0,    16'hFFFF, 16'd5,    4'b0100, 1'b1, 1));
        tbl.push_back(mk(4'h4, 16'h1234, 16'h0004, 16'h2340, 16'h0000, 4'b0010, 1'b0, 1));
        tbl.push_back(mk(4'h6, 16'h8001, 16'h0001, 16'h0003, 16'h0000, 4'b0000, 1'b0, 1));
        tbl.push_back(mk(4'h5, 16'h0003, 16'h0001, 16'h0001, 16'h0000, 4'b0010, 1'b0, 1));
        tbl.push_back(mk(4'h7, 16'h0001, 16'h0001, 16'h8000, 16'h0000, 4'b0100, 1'b0, 1));
        tbl.push_back(mk(4'h4, 16'h5555, 16'h0010, 16'h5555, 16'h0000, 4'b0000, 1'b0, 1));
        tbl.push_back(mk(4'hE, 16'h0005, 16'h0003, 16'h0001, 16'h0000, 4'b0000, 1'b0, 1));
        tbl.push_back(mk(4'hF, 16'h0007, 16'h0008, 16'h0000, 16'h0000, 4'b1000, 1'b0, 1));
        tbl.push_back(mk(4'hD, 16'h00FF, 16'h0F0F, 16'hF00F, 16'h0000, 4'b0100, 1'b0, 1));
        tbl.push_back(mk(4'h2, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0010, 1'b0, 17));
        tbl.push_back(mk(4'h3, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 4'b0100, 1'b0, 17));
        tbl.push_back(mk(4'h0, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b0101, 1'b0, 1));
        tbl.push_back(mk(4'hC, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 4'b1000, 1'b0, 1));

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // MUL with a stray start during the busy phase: exactly one done, at t+17.
        @(negedge clk);
        start = 1'b1; opcode = 4'h2; operand1 = 16'h1234; operand2 = 16'h0100;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; first = 0;
        for (int k = 1; k <= 25; k++) begin
            if (done) begin
                ndone++;
                if (first == 0) first = k;
            end
            if (k == 5) begin
                start = 1'b1; opcode = 4'h0; operand1 = 16'h0001; operand2 = 16'h0001;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("stray done_count", 64'(ndone), 64'd1);
        chk("stray done_cycle", 64'(first), 64'd17);
        chk("stray result", 64'({result_hi, result}), 64'h0012_3400);

        // Reset during MUL: outputs cleared, no done afterwards.
        @(negedge clk);
        start = 1'b1; opcode = 4'h2; operand1 = 16'h1234; operand2 = 16'h0100;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 9) begin
                chk("midreset ready", 64'(ready), 64'd1);
                chk("midreset outputs", 64'({done, result, result_hi}), 64'd0);
                chk("midreset flags",
                    64'({flag_zero, flag_neg, flag_carry, flag_ovf, div_by_zero}), 64'd0);
                reset = 1'b0;
            end else if (done) begin
                ndone++;
            end
            if (k == 8) reset = 1'b1;
            @(posedge clk); #1;
        end
        chk("midreset no_done", 64'(ndone), 64'd0);

        // Random operations against the reference model.
        for (int i = 0; i < 300; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (rop == 4'h3) begin
                case ($urandom_range(0, 3))
                    0: rb = 16'h0;
                    1: rb = 16'($urandom_range(1, 15));
                    default: ;
                endcase
            end
            if ($urandom_range(0, 7) == 0) rb = ra;
            run_vec(model(rop, ra, rb), $sformatf("rnd%0d op%0h a%0h b%0h", i, rop, ra, rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
